// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : mem_arb_pkg                                                     |
// | Brief  : Shared types and constants for the RAM port arbiter.            |
// |          mem_owner_t      - which requester owns the in-flight read      |
// |          MEM_ADDR_W       - RAM word address width                       |
// |          MEM_DATA_W       - RAM word width (two byte lanes)              |
// |          store_byte_en()  - byte address LSB to RAM byte-enable mask     |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 13;
  localparam int MEM_DATA_W = 16;

  // Arbiter side indices used by the fetch/data round-robin.
  localparam logic c_rr_fetch = 1'b0;
  localparam logic c_rr_data  = 1'b1;

  typedef enum logic [1:0] {
    OWNER_NONE  = 2'd0,
    OWNER_FETCH = 2'd1,
    OWNER_DATA  = 2'd2,
    OWNER_DISP  = 2'd3
  } mem_owner_t;

  // Even byte addresses live in the low lane, odd ones in the high lane.
  function automatic logic [1:0] store_byte_en(input logic i_byte_sel);
    return i_byte_sel ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : rr_arb2                                                         |
// | Brief  : Two-input round-robin arbiter with an inhibit input.            |
// |          On a tie the side that was not granted last wins; a lone        |
// |          requester always wins. While i_inhibit is high no grant is      |
// |          issued and the round-robin history is left untouched.           |
// | Ports  : clk, rst_async  - clock, asynchronous active-high reset         |
// |          i_req[1:0]      - requests (bit0 = fetch, bit1 = data)          |
// |          i_inhibit       - suppress all grants this cycle                |
// |          o_gnt[1:0]      - one-hot grant, combinational                  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_async,
  input  logic [1:0] i_req,
  input  logic       i_inhibit,
  output logic [1:0] o_gnt
);

  // Index of the side granted most recently. Reset to the data side so
  // the first contested cycle after reset goes to fetch.
  logic       r_last;
  logic [1:0] w_gnt;

  always_comb begin
    w_gnt = 2'b00;
    if (!i_inhibit) begin
      case (i_req)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = (r_last == c_rr_data) ? 2'b01 : 2'b10;
        default: w_gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      r_last <= c_rr_data;
    end else if (|w_gnt) begin
      r_last <= w_gnt[1] ? c_rr_data : c_rr_fetch;
    end
  end

  assign o_gnt = w_gnt;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : mem_port_arbiter                                                |
// | Brief  : Shares one synchronous 16-bit RAM port between CPU fetch, CPU   |
// |          byte load/store and display scanout. One access per cycle;      |
// |          display has absolute priority, fetch and data alternate on      |
// |          contention. Read data returns one cycle after the grant to the  |
// |          requester that owned the access.                                |
// | Ports  : clk, rst_async           - clock, async active-high reset       |
// |          fetch_req/addr/gnt       - fetch word read request              |
// |          fetch_rvalid/rdata       - fetch read return                    |
// |          data_req/we/addr/wdata   - byte load/store (byte address)       |
// |          data_gnt/rvalid/rdata    - load/store grant, load byte return   |
// |          disp_req/addr/gnt        - display word read request            |
// |          disp_rvalid/rdata        - display read return                  |
// |          mem_addr/we/be/wdata     - RAM command, driven on grant cycle   |
// |          mem_rdata                - RAM read data, one cycle after addr  |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  // Byte-lane steering assumes exactly two 8-bit lanes.
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_async,

  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_rdata,

  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W:0]   data_addr,
  input  logic [7:0]        data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [7:0]        data_rdata,

  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [1:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  logic       w_disp_gnt;
  logic [1:0] w_fd_gnt;

  // Grants are suppressed for the whole time reset is asserted, not just
  // at the clock edge, so nothing reaches the RAM during reset.
  assign w_disp_gnt = disp_req & ~rst_async;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst_async (rst_async),
    .i_req     ({data_req, fetch_req}),
    .i_inhibit (disp_req | rst_async),
    .o_gnt     (w_fd_gnt)
  );

  assign disp_gnt  = w_disp_gnt;
  assign fetch_gnt = w_fd_gnt[0];
  assign data_gnt  = w_fd_gnt[1];

  // ---------------------------------------------------------------------
  // RAM command for the granted requester, and the owner of the read
  // ---------------------------------------------------------------------
  mem_owner_t w_next_owner;
  logic       w_next_byte_sel;

  always_comb begin
    mem_addr        = '0;
    mem_we          = 1'b0;
    mem_be          = 2'b00;
    mem_wdata       = '0;
    w_next_owner    = OWNER_NONE;
    w_next_byte_sel = 1'b0;

    if (w_disp_gnt) begin
      mem_addr     = disp_addr;
      mem_be       = 2'b11;
      w_next_owner = OWNER_DISP;
    end else if (w_fd_gnt[0]) begin
      mem_addr     = fetch_addr;
      mem_be       = 2'b11;
      w_next_owner = OWNER_FETCH;
    end else if (w_fd_gnt[1]) begin
      mem_addr = data_addr[ADDR_W:1];
      if (data_we) begin
        // Replicating the byte onto both lanes lets the byte enable alone
        // pick the lane; a store leaves no read in flight.
        mem_we    = 1'b1;
        mem_be    = store_byte_en(data_addr[0]);
        mem_wdata = {2{data_wdata}};
      end else begin
        mem_be          = 2'b11;
        w_next_owner    = OWNER_DATA;
        w_next_byte_sel = data_addr[0];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read return tracking
  // ---------------------------------------------------------------------
  // Reloaded every cycle: an access issued this cycle returns next cycle,
  // and with no read granted the owner falls back to NONE. Reset clears it
  // asynchronously so a read in flight at reset is dropped.
  mem_owner_t r_owner;
  logic       r_byte_sel;

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      r_owner    <= OWNER_NONE;
      r_byte_sel <= 1'b0;
    end else begin
      r_owner    <= w_next_owner;
      r_byte_sel <= w_next_byte_sel;
    end
  end

  assign fetch_rvalid = (r_owner == OWNER_FETCH);
  assign data_rvalid  = (r_owner == OWNER_DATA);
  assign disp_rvalid  = (r_owner == OWNER_DISP);

  assign fetch_rdata  = mem_rdata;
  assign disp_rdata   = mem_rdata;
  assign data_rdata   = r_byte_sel ? mem_rdata[DATA_W-1:DATA_W/2]
                                   : mem_rdata[DATA_W/2-1:0];

endmodule
`default_nettype wire
